mdu_unit: RTL and testbench

- Multiply/divide responder at the far end of the Start handshake carried by the ID/EX pipeline register.
- Accepts a one-cycle Start pulse with operation and operands from EX.
- Runs a fixed-latency multiply or divide, asserting Busy while active, and holds the architectural HI/LO registers.
- The hazard unit stalls any HI/LO-dependent instruction in ID while Start or Busy is high.

---
 rtl/mdu_unit.sv | 154 +++++++++++++++
 tb/tb_mdu_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers; fixed-latency ops with Busy.
// Optional madd/msub accumulate ops are built when MDU_MADD_EN is defined.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // Result captured at accept; skip marks a divide by zero that must not commit.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        skip;
    } mdu_res_t;

    state_t   state, state_nxt;
    logic [7:0] cnt;
    mdu_res_t res_q, res_d;

    logic is_mul, is_div, accept, mt_wr, last, commit;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    // ---------------- decode ----------------
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (MDOp)
            OP_MULT, OP_MULTU: is_mul = 1'b1;
            OP_DIV, OP_DIVU:   is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB:  is_mul = 1'b1;
`endif
            default: ;
        endcase
    end

    assign accept = (state == S_IDLE) && Start && !Flush && (is_mul || is_div);
    assign mt_wr  = (state == S_IDLE) && Start && !Flush &&
                    ((MDOp == OP_MTHI) || (MDOp == OP_MTLO));
    assign last   = (cnt <= 8'd1);
    assign commit = (state == S_BUSY) && !Flush && last;
    assign Busy   = (state == S_BUSY);

    // ---------------- arithmetic ----------------
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    // Signed divide on magnitudes so quotient truncates toward zero and the
    // remainder follows the dividend; the zero guards keep X out of the datapath.
    assign a_mag      = A[31] ? -A : A;
    assign b_mag      = B[31] ? -B : B;
    assign b_mag_safe = (B == 32'd0) ? 32'd1 : b_mag;
    assign b_u_safe   = (B == 32'd0) ? 32'd1 : B;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (A[31] ^ B[31]) ? -q_mag : q_mag;
    assign r_s        = A[31] ? -r_mag : r_mag;
    assign q_u        = A / b_u_safe;
    assign r_u        = A % b_u_safe;

    always_comb begin
        res_d = '0;
        case (MDOp)
            OP_MULT:  {res_d.hi, res_d.lo} = prod_s;
            OP_MULTU: {res_d.hi, res_d.lo} = prod_u;
            OP_DIV: begin
                res_d.hi   = r_s;
                res_d.lo   = q_s;
                res_d.skip = (B == 32'd0);
            end
            OP_DIVU: begin
                res_d.hi   = r_u;
                res_d.lo   = q_u;
                res_d.skip = (B == 32'd0);
            end
`ifdef MDU_MADD_EN
            // Accumulate base is HI/LO as seen at the accepting edge.
            OP_MADD:  {res_d.hi, res_d.lo} = {HI, LO} + prod_s;
            OP_MSUB:  {res_d.hi, res_d.lo} = {HI, LO} - prod_s;
`endif
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_BUSY;
            S_BUSY: if (Flush || last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- counter, result and HI/LO ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 8'd0;
            res_q <= '0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            if (accept) begin
                res_q <= res_d;
                cnt   <= is_mul ? MULT_CNT : DIV_CNT;
            end else if (state == S_BUSY) begin
                cnt <= (Flush || last) ? 8'd0 : cnt - 8'd1;
            end

            if (mt_wr) begin
                if (MDOp == OP_MTHI) HI <= A;
                else                 LO <= A;
            end

            if (commit && !res_q.skip) begin
                HI <= res_q.hi;
                LO <= res_q.lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against a plain-arithmetic model.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .Flush(Flush), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: updates m_hi/m_lo and returns the expected busy length.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cyc);
        longint sa, sb, p;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        p   = sa * sb;
        cyc = 0;
        case (op)
            3'd0: begin {m_hi, m_lo} = p; cyc = MC; end
            3'd1: begin acc = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = acc; cyc = MC; end
            3'd2: begin
                cyc = DC;
                if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            end
            3'd3: begin
                cyc = DC;
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: begin
`ifdef MDU_MADD_EN
                acc = {m_hi, m_lo};
                acc = (op == 3'd6) ? acc + 64'(p) : acc - 64'(p);
                {m_hi, m_lo} = acc;
                cyc = MC;
`endif
            end
        endcase
    endtask

    // Called just after a negedge; returns after the first negedge with Busy low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; A = $urandom; B = $urandom;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0; Flush = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b want 0", Busy); end
    endtask

    task automatic test_mult();
        int cyc, ec;
        model_op(3'd0, 32'hFFFFFFFE, 32'h3, ec);
        run_op(3'd0, 32'hFFFFFFFE, 32'h3, cyc);
        checks++; if (cyc != MC) begin errors++; $display("FAIL mult_busy: got %0d want %0d", cyc, MC); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
        model_op(3'd1, 32'hFFFFFFFE, 32'h3, ec);
        run_op(3'd1, 32'hFFFFFFFE, 32'h3, cyc);
        checks++; if (cyc != MC) begin errors++; $display("FAIL multu_busy: got %0d want %0d", cyc, MC); end
        checks++; if (HI !== 32'h2) begin errors++; $display("FAIL multu_hi: got %h want 00000002", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo: got %h want fffffffa", LO); end
    endtask

    task automatic test_div();
        int cyc, ec;
        model_op(3'd2, 32'hFFFFFFF9, 32'h2, ec);
        run_op(3'd2, 32'hFFFFFFF9, 32'h2, cyc);
        checks++; if (cyc != DC) begin errors++; $display("FAIL div_busy: got %0d want %0d", cyc, DC); end
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", HI); end
        model_op(3'd3, 32'd7, 32'd0, ec);
        run_op(3'd3, 32'd7, 32'd0, cyc);
        checks++; if (cyc != DC) begin errors++; $display("FAIL divu0_busy: got %0d want %0d", cyc, DC); end
        checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD)
            begin errors++; $display("FAIL divu0_hold: got %h/%h want ffffffff/fffffffd", HI, LO); end
    endtask

    task automatic test_mthi_mtlo();
        int cyc, ec;
        model_op(3'd4, 32'h12345678, 32'h0, ec);
        run_op(3'd4, 32'h12345678, 32'h0, cyc);
        checks++; if (cyc != 0) begin errors++; $display("FAIL mthi_busy: got %0d want 0", cyc); end
        checks++; if (HI !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
        model_op(3'd5, 32'hCAFEF00D, 32'h0, ec);
        run_op(3'd5, 32'hCAFEF00D, 32'h0, cyc);
        checks++; if (LO !== 32'hCAFEF00D || HI !== 32'h12345678)
            begin errors++; $display("FAIL mtlo: got %h/%h want 12345678/cafef00d", HI, LO); end
    endtask

    // Start pulses during BUSY (mtlo, then a mult) must be ignored.
    task automatic test_start_while_busy();
        int cyc, ec;
        model_op(3'd2, 32'hFFFFFFF9, 32'h2, ec);
        Start = 1'b1; MDOp = 3'd2; A = 32'hFFFFFFF9; B = 32'h2;
        @(negedge clk);
        Start = 1'b0;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 300) begin
            cyc++;
            if (cyc == 3) begin Start = 1'b1; MDOp = 3'd5; A = 32'hDEADBEEF; end
            else if (cyc == 4) begin Start = 1'b1; MDOp = 3'd0; A = 32'd3; B = 32'd3; end
            else Start = 1'b0;
            @(negedge clk);
        end
        Start = 1'b0;
        checks++; if (cyc != DC) begin errors++; $display("FAIL busy_ignore_len: got %0d want %0d", cyc, DC); end
        checks++; if (LO !== 32'hFFFFFFFD) begin errors++; $display("FAIL busy_ignore_lo: got %h want fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin errors++; $display("FAIL busy_ignore_hi: got %h want ffffffff", HI); end
        @(negedge clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle: busy %b want 0", Busy); end
    endtask

    task automatic test_flush();
        int cyc;
        // Flush in 3rd busy cycle.
        Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: busy %b want 1", Busy); end
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_busy: busy %b want 0", Busy); end
        checks++; if (HI !== m_hi || LO !== m_lo)
            begin errors++; $display("FAIL flush_hold: got %h/%h want %h/%h", HI, LO, m_hi, m_lo); end
        // Flush on the final busy cycle still cancels the commit.
        Start = 1'b1; MDOp = 3'd0; A = 32'd9; B = 32'd9;
        @(negedge clk);
        Start = 1'b0;
        cyc = 1;
        while (Busy === 1'b1 && cyc < MC) begin cyc++; @(negedge clk); end
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo)
            begin errors++; $display("FAIL flush_last: got %b %h/%h want 0 %h/%h", Busy, HI, LO, m_hi, m_lo); end
        // Flush with Start in IDLE: Start dropped.
        Start = 1'b1; Flush = 1'b1; MDOp = 3'd4; A = 32'h55555555;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        checks++; if (HI !== m_hi) begin errors++; $display("FAIL flush_start_mthi: got %h want %h", HI, m_hi); end
        Start = 1'b1; Flush = 1'b1; MDOp = 3'd1; A = 32'd2; B = 32'd2;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL flush_start_mult: busy %b want 0", Busy); end
    endtask

    task automatic test_async_reset();
        int cyc, ec;
        model_op(3'd4, 32'hA5A5A5A5, 32'h0, ec); run_op(3'd4, 32'hA5A5A5A5, 32'h0, cyc);
        model_op(3'd5, 32'h5A5A5A5A, 32'h0, ec); run_op(3'd5, 32'h5A5A5A5A, 32'h0, cyc);
        Start = 1'b1; MDOp = 3'd0; A = 32'd4; B = 32'd5;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        checks++; if (Busy !== 1'b1 || HI !== 32'hA5A5A5A5)
            begin errors++; $display("FAIL areset_pre: got %b %h want 1 a5a5a5a5", Busy, HI); end
        #2 reset = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            begin errors++; $display("FAIL areset_now: got %b %h/%h want 0 0/0", Busy, HI, LO); end
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            begin errors++; $display("FAIL areset_after: got %b %h/%h want 0 0/0", Busy, HI, LO); end
    endtask

    task automatic test_madd();
        int cyc, ec;
        model_op(3'd4, 32'h0, 32'h0, ec);  run_op(3'd4, 32'h0, 32'h0, cyc);
        model_op(3'd5, 32'h10, 32'h0, ec); run_op(3'd5, 32'h10, 32'h0, cyc);
        model_op(3'd6, 32'hFFFFFFFF, 32'h4, ec);
        run_op(3'd6, 32'hFFFFFFFF, 32'h4, cyc);
`ifdef MDU_MADD_EN
        checks++; if (cyc != MC) begin errors++; $display("FAIL madd_busy: got %0d want %0d", cyc, MC); end
        checks++; if (HI !== 32'h0 || LO !== 32'hC)
            begin errors++; $display("FAIL madd_result: got %h/%h want 00000000/0000000c", HI, LO); end
`else
        checks++; if (cyc != 0) begin errors++; $display("FAIL madd_off_busy: got %0d want 0", cyc); end
        checks++; if (HI !== 32'h0 || LO !== 32'h10)
            begin errors++; $display("FAIL madd_off_hold: got %h/%h want 00000000/00000010", HI, LO); end
`endif
        checks++; if (HI !== m_hi || LO !== m_lo)
            begin errors++; $display("FAIL madd_model: got %h/%h want %h/%h", HI, LO, m_hi, m_lo); end
    endtask

    // Random ops issued back to back against the model.
    task automatic test_random();
        int cyc, ec;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($signed($urandom_range(0, 40)) - 20);
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = 32'h80000000;
            model_op(op, a, b, ec);
            run_op(op, a, b, cyc);
            checks++; if (cyc != ec) begin errors++; $display("FAIL rand%0d_busy op%0d: got %0d want %0d", i, op, cyc, ec); end
            checks++; if (HI !== m_hi || LO !== m_lo)
                begin errors++; $display("FAIL rand%0d_hilo op%0d a=%h b=%h: got %h/%h want %h/%h", i, op, a, b, HI, LO, m_hi, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_start_while_busy();
        test_flush();
        test_async_reset();
        test_madd();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
